// File: rtl/decode_stage_pkg.sv
// Shared constants and types for the decode stage: opcodes, the injected NOP,
// and instruction field positions.
package decode_stage_pkg;

    localparam int DATA_W = 16;
    localparam int NUM_REGS = 8;
    localparam int REG_AW = 3;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [4:0] opcode_t;

    localparam opcode_t OP_HALT = 5'b00000;
    localparam opcode_t OP_NOP  = 5'b00001;
    localparam opcode_t OP_ST   = 5'b10000;
    localparam opcode_t OP_LD   = 5'b10001;

    localparam word_t NOP_INSTR = {OP_NOP, 11'b0};

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 11;
    localparam int RS_MSB  = 10;
    localparam int RS_LSB  = 8;
    localparam int RT_MSB  = 7;
    localparam int RT_LSB  = 5;

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-to-decode bus: the fetched instruction and its PC+2 flow down,
// the stall (fetch PC hold) flows back up; flush comes from branch resolution.
interface decode_stage_if
    import decode_stage_pkg::*;
#(
    parameter int WIDTH = DATA_W
);
    logic [WIDTH-1:0] if_instr;
    logic [WIDTH-1:0] if_nextPC;
    logic             flush;
    logic             stall;

    modport master (
        output if_instr,
        output if_nextPC,
        output flush,
        input  stall
    );

    modport slave (
        input  if_instr,
        input  if_nextPC,
        input  flush,
        output stall
    );
endinterface

// File: rtl/decode_stage_rf_bypass.sv
// Architectural register file: synchronous write port, two combinational read
// ports, each with write-before-read bypass from writeback.
module decode_stage_rf_bypass
    import decode_stage_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int NREGS = NUM_REGS,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    rs_addr_i,
    input  logic [AW-1:0]    rt_addr_i,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic [WIDTH-1:0] rs_data_o,
    output logic [WIDTH-1:0] rt_data_o
);

    logic [WIDTH-1:0] regs_q [NREGS];

    // NOTE: the array is cleared on reset because software expects all
    // registers to start at zero; a reset memory cannot map onto a RAM macro.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            regs_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Writeback lands in the same cycle the reader needs it.
    assign rs_data_o = (wr_en_i && wr_addr_i == rs_addr_i) ? wr_data_i : regs_q[rs_addr_i];
    assign rt_data_o = (wr_en_i && wr_addr_i == rt_addr_i) ? wr_data_i : regs_q[rt_addr_i];

endmodule

// File: rtl/decode_stage.sv
// Decode stage: IF/ID latch, register-file read with bypass, immediate
// extraction and load-use hazard detection driving the fetch stall.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int          WIDTH     = DATA_W,
    parameter int          NREGS     = NUM_REGS,
    parameter logic [15:0] NOP_WORD  = NOP_INSTR
) (
    input  logic                     clk,
    input  logic                     rst,
    decode_stage_if.slave            fetch,
    input  logic                     ex_memRead,
    input  logic [$clog2(NREGS)-1:0] ex_rd,
    input  logic                     wb_en,
    input  logic [$clog2(NREGS)-1:0] wb_reg,
    input  logic [WIDTH-1:0]         wb_data,
    output logic                     id_valid,
    output logic [WIDTH-1:0]         id_instr,
    output logic [WIDTH-1:0]         id_pc,
    output logic [WIDTH-1:0]         rs_data,
    output logic [WIDTH-1:0]         rt_data,
    output logic [WIDTH-1:0]         imm5_s,
    output logic [WIDTH-1:0]         imm5_z,
    output logic [WIDTH-1:0]         imm8_s,
    output logic [WIDTH-1:0]         imm8_z,
    output logic [WIDTH-1:0]         disp11_s,
    output logic                     halt_dec
);

    localparam int AW = $clog2(NREGS);

    logic [WIDTH-1:0] instr_q, instr_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             valid_q, valid_d;
    logic [AW-1:0]    rs_addr, rt_addr;
    logic             hz;
    logic             stall;

    assign rs_addr = instr_q[RS_MSB:RS_LSB];
    assign rt_addr = instr_q[RT_MSB:RT_LSB];

    // Both source fields are compared whatever the format; a spurious stall
    // costs a cycle, a missed one returns stale data.
    assign hz    = valid_q && ex_memRead && ((ex_rd == rs_addr) || (ex_rd == rt_addr));
    assign stall = hz && !fetch.flush;
    assign fetch.stall = stall;

    // NOTE: every next-state variable takes its hold value first so no path
    // through the block leaves it unassigned and infers a latch.
    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        if (fetch.flush) begin
            instr_d = NOP_WORD;
            valid_d = 1'b0;
        end else if (!stall) begin
            instr_d = fetch.if_instr;
            pc_d    = fetch.if_nextPC;
            valid_d = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q <= NOP_WORD;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    // A stalled instruction is held here but execute sees a bubble.
    assign id_valid = valid_q && !stall;
    assign id_instr = id_valid ? instr_q : NOP_WORD;
    assign id_pc    = pc_q;
    assign halt_dec = id_valid && (instr_q[OPC_MSB:OPC_LSB] == OP_HALT);

    assign imm5_s   = {{(WIDTH-5){instr_q[4]}}, instr_q[4:0]};
    assign imm5_z   = {{(WIDTH-5){1'b0}}, instr_q[4:0]};
    assign imm8_s   = {{(WIDTH-8){instr_q[7]}}, instr_q[7:0]};
    assign imm8_z   = {{(WIDTH-8){1'b0}}, instr_q[7:0]};
    assign disp11_s = {{(WIDTH-11){instr_q[10]}}, instr_q[10:0]};

    decode_stage_rf_bypass #(
        .WIDTH (WIDTH),
        .NREGS (NREGS)
    ) u_rf (
        .clk       (clk),
        .rst       (rst),
        .rs_addr_i (rs_addr),
        .rt_addr_i (rt_addr),
        .wr_en_i   (wb_en),
        .wr_addr_i (wb_reg),
        .wr_data_i (wb_data),
        .rs_data_o (rs_data),
        .rt_data_o (rt_data)
    );

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: reset, straight flow, bypass, load-use,
// flush priority, halt/immediates and reset during a stall.
module tb_decode_stage;
    import decode_stage_pkg::*;

    logic        clk;
    logic        rst;
    logic        ex_memRead;
    logic [2:0]  ex_rd;
    logic        wb_en;
    logic [2:0]  wb_reg;
    logic [15:0] wb_data;
    logic        id_valid;
    logic [15:0] id_instr, id_pc, rs_data, rt_data;
    logic [15:0] imm5_s, imm5_z, imm8_s, imm8_z, disp11_s;
    logic        halt_dec;

    int checks = 0;
    int failures = 0;

    decode_stage_if fif ();

    decode_stage dut (
        .clk        (clk),
        .rst        (rst),
        .fetch      (fif),
        .ex_memRead (ex_memRead),
        .ex_rd      (ex_rd),
        .wb_en      (wb_en),
        .wb_reg     (wb_reg),
        .wb_data    (wb_data),
        .id_valid   (id_valid),
        .id_instr   (id_instr),
        .id_pc      (id_pc),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .imm5_s     (imm5_s),
        .imm5_z     (imm5_z),
        .imm8_s     (imm8_s),
        .imm8_z     (imm8_z),
        .disp11_s   (disp11_s),
        .halt_dec   (halt_dec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; checks run 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", id_valid); end
        checks++; if (id_instr !== 16'h0800) begin failures++; $display("FAIL reset_instr got=%h exp=0800", id_instr); end
        checks++; if (id_pc !== 16'h0000) begin failures++; $display("FAIL reset_pc got=%h exp=0000", id_pc); end
        checks++; if (fif.stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", fif.stall); end
        checks++; if (halt_dec !== 1'b0) begin failures++; $display("FAIL reset_halt got=%b exp=0", halt_dec); end
        checks++; if (rs_data !== 16'h0000 || rt_data !== 16'h0000) begin failures++; $display("FAIL reset_rf got=%h/%h exp=0000/0000", rs_data, rt_data); end
        // Register 0 is an ordinary register: bypass then array read.
        wb_en = 1'b1; wb_reg = 3'd0; wb_data = 16'h00AA;
        #1;
        checks++; if (rs_data !== 16'h00AA || rt_data !== 16'h00AA) begin failures++; $display("FAIL r0_bypass got=%h/%h exp=00aa/00aa", rs_data, rt_data); end
        tick();
        wb_en = 1'b0;
        #1;
        checks++; if (rs_data !== 16'h00AA) begin failures++; $display("FAIL r0_array got=%h exp=00aa", rs_data); end
    endtask

    task automatic test_flow();
        fif.if_instr = 16'h4125; fif.if_nextPC = 16'h0002;
        tick();
        #1;
        checks++; if (id_valid !== 1'b1) begin failures++; $display("FAIL flow_valid got=%b exp=1", id_valid); end
        checks++; if (id_instr !== 16'h4125) begin failures++; $display("FAIL flow_instr got=%h exp=4125", id_instr); end
        checks++; if (id_pc !== 16'h0002) begin failures++; $display("FAIL flow_pc got=%h exp=0002", id_pc); end
        checks++; if (imm5_s !== 16'h0005 || imm5_z !== 16'h0005) begin failures++; $display("FAIL flow_imm5 got=%h/%h exp=0005/0005", imm5_s, imm5_z); end
        checks++; if (imm8_z !== 16'h0025 || imm8_s !== 16'h0025) begin failures++; $display("FAIL flow_imm8 got=%h/%h exp=0025/0025", imm8_z, imm8_s); end
        checks++; if (disp11_s !== 16'h0125) begin failures++; $display("FAIL flow_disp11 got=%h exp=0125", disp11_s); end
        checks++; if (halt_dec !== 1'b0 || fif.stall !== 1'b0) begin failures++; $display("FAIL flow_ctl got=%b/%b exp=0/0", halt_dec, fif.stall); end
    endtask

    task automatic test_bypass();
        // 0x4360: rs = rt = 3
        fif.if_instr = 16'h4360; fif.if_nextPC = 16'h0004;
        tick();
        wb_en = 1'b1; wb_reg = 3'd3; wb_data = 16'hBEEF;
        #1;
        checks++; if (rs_data !== 16'hBEEF || rt_data !== 16'hBEEF) begin failures++; $display("FAIL bypass_same got=%h/%h exp=beef/beef", rs_data, rt_data); end
        tick();
        wb_reg = 3'd5; wb_data = 16'h1234;
        #1;
        checks++; if (rs_data !== 16'hBEEF || rt_data !== 16'hBEEF) begin failures++; $display("FAIL bypass_other got=%h/%h exp=beef/beef", rs_data, rt_data); end
        tick();
        wb_en = 1'b0;
        #1;
        checks++; if (rs_data !== 16'hBEEF) begin failures++; $display("FAIL bypass_array got=%h exp=beef", rs_data); end
    endtask

    task automatic test_load_use();
        // 0x2540: rs = 5, rt = 2
        fif.if_instr = 16'h2540; fif.if_nextPC = 16'h0010;
        tick();
        fif.if_instr = 16'h6AAA; fif.if_nextPC = 16'h0012;
        ex_memRead = 1'b1; ex_rd = 3'd2;
        #1;
        checks++; if (fif.stall !== 1'b1) begin failures++; $display("FAIL lu_stall got=%b exp=1", fif.stall); end
        checks++; if (id_valid !== 1'b0 || id_instr !== 16'h0800) begin failures++; $display("FAIL lu_bubble got=%b/%h exp=0/0800", id_valid, id_instr); end
        checks++; if (rs_data !== 16'h1234) begin failures++; $display("FAIL lu_rs got=%h exp=1234", rs_data); end
        tick();
        checks++; if (id_pc !== 16'h0010 || rs_data !== 16'h1234) begin failures++; $display("FAIL lu_hold got=%h/%h exp=0010/1234", id_pc, rs_data); end
        ex_memRead = 1'b0;
        #1;
        checks++; if (fif.stall !== 1'b0 || id_valid !== 1'b1 || id_instr !== 16'h2540) begin failures++; $display("FAIL lu_issue got=%b/%b/%h exp=0/1/2540", fif.stall, id_valid, id_instr); end
        tick();
        checks++; if (id_instr !== 16'h6AAA || id_pc !== 16'h0012) begin failures++; $display("FAIL lu_next got=%h/%h exp=6aaa/0012", id_instr, id_pc); end
    endtask

    task automatic test_flush_vs_stall();
        // 0x6AAA: rs = 2, rt = 5
        fif.if_instr = 16'h7777; fif.if_nextPC = 16'h0014;
        ex_memRead = 1'b1; ex_rd = 3'd5;
        #1;
        checks++; if (fif.stall !== 1'b1) begin failures++; $display("FAIL fs_hz got=%b exp=1", fif.stall); end
        fif.flush = 1'b1;
        #1;
        checks++; if (fif.stall !== 1'b0) begin failures++; $display("FAIL fs_stall got=%b exp=0", fif.stall); end
        tick();
        fif.flush = 1'b0; ex_rd = 3'd0;
        #1;
        checks++; if (id_valid !== 1'b0 || id_instr !== 16'h0800) begin failures++; $display("FAIL fs_nop got=%b/%h exp=0/0800", id_valid, id_instr); end
        checks++; if (id_pc !== 16'h0012) begin failures++; $display("FAIL fs_pc got=%h exp=0012", id_pc); end
        checks++; if (fif.stall !== 1'b0) begin failures++; $display("FAIL fs_bubble_nohz got=%b exp=0", fif.stall); end
        ex_memRead = 1'b0;
    endtask

    task automatic test_halt();
        fif.if_instr = 16'h07FF; fif.if_nextPC = 16'h0020;
        tick();
        #1;
        checks++; if (halt_dec !== 1'b1 || id_instr !== 16'h07FF) begin failures++; $display("FAIL halt_dec got=%b/%h exp=1/07ff", halt_dec, id_instr); end
        checks++; if (disp11_s !== 16'hFFFF) begin failures++; $display("FAIL halt_disp11 got=%h exp=ffff", disp11_s); end
        checks++; if (imm5_s !== 16'hFFFF || imm5_z !== 16'h001F) begin failures++; $display("FAIL halt_imm5 got=%h/%h exp=ffff/001f", imm5_s, imm5_z); end
        checks++; if (imm8_s !== 16'hFFFF || imm8_z !== 16'h00FF) begin failures++; $display("FAIL halt_imm8 got=%h/%h exp=ffff/00ff", imm8_s, imm8_z); end
        ex_memRead = 1'b1; ex_rd = 3'd7;
        #1;
        checks++; if (halt_dec !== 1'b0 || fif.stall !== 1'b1) begin failures++; $display("FAIL halt_stalled got=%b/%b exp=0/1", halt_dec, fif.stall); end
        ex_memRead = 1'b0; fif.flush = 1'b1;
        tick();
        fif.flush = 1'b0;
        #1;
        checks++; if (halt_dec !== 1'b0 || id_valid !== 1'b0) begin failures++; $display("FAIL halt_flushed got=%b/%b exp=0/0", halt_dec, id_valid); end
    endtask

    task automatic test_reset_mid_stall();
        fif.if_instr = 16'h2540; fif.if_nextPC = 16'h0030;
        tick();
        ex_memRead = 1'b1; ex_rd = 3'd2;
        #1;
        checks++; if (fif.stall !== 1'b1) begin failures++; $display("FAIL rms_stall got=%b exp=1", fif.stall); end
        rst = 1'b1; wb_en = 1'b1; wb_reg = 3'd5; wb_data = 16'h5555;
        tick();
        rst = 1'b0; wb_en = 1'b0; ex_memRead = 1'b0;
        #1;
        checks++; if (id_valid !== 1'b0 || id_instr !== 16'h0800 || id_pc !== 16'h0000) begin failures++; $display("FAIL rms_latch got=%b/%h/%h exp=0/0800/0000", id_valid, id_instr, id_pc); end
        checks++; if (rs_data !== 16'h0000) begin failures++; $display("FAIL rms_r0 got=%h exp=0000", rs_data); end
        tick();
        #1;
        checks++; if (id_valid !== 1'b1 || rs_data !== 16'h0000 || rt_data !== 16'h0000) begin failures++; $display("FAIL rms_rf got=%b/%h/%h exp=1/0000/0000", id_valid, rs_data, rt_data); end
    endtask

    initial begin
        rst = 1'b1;
        fif.if_instr = 16'h0800; fif.if_nextPC = 16'h0000; fif.flush = 1'b0;
        ex_memRead = 1'b0; ex_rd = 3'd0;
        wb_en = 1'b0; wb_reg = 3'd0; wb_data = 16'h0000;
        test_reset();
        test_flow();
        test_bypass();
        test_load_use();
        test_flush_vs_stall();
        test_halt();
        test_reset_mid_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
